gctrl_mw: RTL

// - Parametrised successor of the global bit-serial controller for the DCIM macro; sequences input-bit select over a runtime-chosen width.
// - Adds multi-pass weight-bank sequencing, stall, abort, and a one-cycle done pulse.
// - Sits between the top-level command interface and the macro's input-bit mux and shift-accumulate datapath.

---
 rtl/gctrl_pkg.sv | 28 ++
 rtl/gctrl_bitcnt.sv | 41 ++++
 rtl/gctrl_mw.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gctrl_pkg.sv
// Shared types and helpers for the bit-serial global controller.
package gctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_4B  = 2'd0,
        MODE_8B  = 2'd1,
        MODE_12B = 2'd2,
        MODE_24B = 2'd3
    } mode_e;

    // Map a mode code onto the input width chosen for that mode.
    function automatic int width_of(input logic [1:0] mode,
                                    input int w0, input int w1,
                                    input int w2, input int w3);
        case (mode_e'(mode))
            MODE_4B:  return w0;
            MODE_8B:  return w1;
            MODE_12B: return w2;
            default:  return w3;
        endcase
    endfunction

endpackage

// File: rtl/gctrl_bitcnt.sv
// Input-bit index counter: load-zero, enable, terminal count at last_val.
module gctrl_bitcnt
    import gctrl_pkg::*;
#(
    parameter int SEL_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [SEL_W-1:0] last_val,
    output logic [SEL_W-1:0] cnt,
    output logic             tc
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    // Next count: clearing takes precedence over advancing; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == last_val);

endmodule

// File: rtl/gctrl_mw.sv
// Global bit-serial controller: walks sel over W input bits for P weight-bank
// passes, with stall, abort and a one-cycle done pulse on normal completion.
module gctrl_mw
    import gctrl_pkg::*;
#(
    parameter int SEL_W  = 6,
    parameter int BANK_W = 2,
    parameter int WIDTH0 = 4,
    parameter int WIDTH1 = 8,
    parameter int WIDTH2 = 12,
    parameter int WIDTH3 = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [BANK_W-1:0] npass,
    input  logic              stall,
    input  logic              abort,
    output logic [SEL_W-1:0]  sel,
    output logic [BANK_W-1:0] bank,
    output logic              st,
    output logic              busy,
    output logic              first_bit,
    output logic              last_bit,
    output logic              step,
    output logic              done
);

    localparam logic [3:0][31:0] WIDTHS = {WIDTH3, WIDTH2, WIDTH1, WIDTH0};

    // Every configured width must be reachable by the sel counter.
    for (genvar gi = 0; gi < 4; gi++) begin : g_width_chk
        if (int'(WIDTHS[gi]) < 1 || int'(WIDTHS[gi]) > (2 ** SEL_W)) begin : g_bad
            $fatal(1, "gctrl_mw: WIDTH%0d out of range 1..2**SEL_W", gi);
        end
    end

    state_e            state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              done_q, done_d;
    logic [SEL_W-1:0]  wm1_q, wm1_d;   // latched W-1
    logic [BANK_W:0]   p_q, p_d;       // latched P, one extra bit so 2**BANK_W fits
    logic              cnt_clr, cnt_en;
    logic              sel_tc;
    logic              last_pass;

    gctrl_bitcnt #(
        .SEL_W (SEL_W)
    ) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .last_val (wm1_q),
        .cnt      (sel),
        .tc       (sel_tc)
    );

    assign last_pass = ({1'b0, bank_q} == (p_q - 1'b1));

    // Next-state and counter control; abort outranks stall and completion.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        wm1_d   = wm1_q;
        p_d     = p_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    wm1_d   = SEL_W'(width_of(mode, WIDTH0, WIDTH1, WIDTH2, WIDTH3) - 1);
                    p_d     = {1'b0, npass};
                    if (npass == '0) begin
                        p_d = {1'b1, {BANK_W{1'b0}}};
                    end
                    cnt_clr = 1'b1;
                    bank_d  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    if (!sel_tc) begin
                        cnt_en = 1'b1;
                    end else if (!last_pass) begin
                        cnt_clr = 1'b1;
                        bank_d  = bank_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bank_q  <= '0;
            done_q  <= 1'b0;
            wm1_q   <= '0;
            p_q     <= {{BANK_W{1'b0}}, 1'b1};
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            wm1_q   <= wm1_d;
            p_q     <= p_d;
        end
    end

    assign bank      = bank_q;
    assign done      = done_q;
    assign st        = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign first_bit = busy && (sel == '0);
    assign last_bit  = busy && sel_tc;
    assign step      = busy && !stall;

endmodule
